fifo_ram_ctrl: RTL and testbench

FIFO_RAM_CTRL -- requirements
Module: fifo_ram_ctrl

---
 rtl/fifo_ram_pkg.sv | 13 +
 rtl/fifo_ram_ctrl.sv | 88 ++++++++
 tb/tb_fifo_ram_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ram_pkg.sv
// rtl/fifo_ram_pkg.sv - shared constants and output FSM encoding for fifo_ram_ctrl
package fifo_ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_ram_ctrl.sv
// rtl/fifo_ram_ctrl.sv - FIFO controller over an external registered-read RAM
module fifo_ram_ctrl
  import fifo_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_rd_ready,
  output logic              o_ram_write,
  output logic [ADDR_W-1:0] o_ram_addr_wr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic [ADDR_W-1:0] o_ram_addr_r,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  state_e            state_q, state_d;
  logic              push, pop;

  // The HOLD entry stays counted until popped, so full covers all 32 slots.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign o_full  = (count == DEPTH);
  assign o_empty = (count == '0);

  assign push = i_wr_valid && !o_full && i_rst_n;
  assign pop  = (state_q == HOLD) && i_rd_ready;

  assign o_wr_ready    = !o_full;
  assign o_rd_valid    = (state_q == HOLD);
  assign o_rd_data     = rd_data_q;
  assign o_count       = count;
  assign o_ram_write   = push;
  assign o_ram_addr_wr = wr_ptr_q[ADDR_W-1:0];
  assign o_ram_wdata   = i_wr_data;
  assign o_ram_addr_r  = rd_ptr_q[ADDR_W-1:0];

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    rd_data_d = rd_data_q;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        // Registered count: a push at E0 is first fetched from E1 on.
        if (count != '0) state_d = FETCH;
      end
      FETCH: begin
        rd_data_d = i_ram_rdata;
        state_d   = HOLD;
      end
      HOLD: begin
        if (i_rd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      state_q   <= IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb/tb_fifo_ram_ctrl.sv - self-checking bench for fifo_ram_ctrl with a behavioural RAM and queue model
module tb_fifo_ram_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic          ram_write;
  logic [AW-1:0] ram_addr_wr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_rdata;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  always #5 clk = ~clk;

  fifo_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wr_valid   (wr_valid),
    .i_wr_data    (wr_data),
    .o_wr_ready   (wr_ready),
    .o_rd_valid   (rd_valid),
    .o_rd_data    (rd_data),
    .i_rd_ready   (rd_ready),
    .o_ram_write  (ram_write),
    .o_ram_addr_wr(ram_addr_wr),
    .o_ram_wdata  (ram_wdata),
    .o_ram_addr_r (ram_addr_r),
    .i_ram_rdata  (ram_rdata),
    .o_count      (count),
    .o_full       (full),
    .o_empty      (empty)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr_wr] <= ram_wdata;
    ram_rdata <= mem[ram_addr_r];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a plain queue of stored entries; the head becomes visible
  // two edges after it is eligible (queue non-empty and not just popped).
  logic [DW-1:0] q[$];
  logic [DW-1:0] popped[$];
  int age      = 0;
  int wr_total = 0;
  int rd_total = 0;

  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic          ev;
    logic [DW-1:0] ed;
    logic [AW:0]   ec;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic rn);
    logic exp_push, exp_pop, had;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    rst_n    = rn;
    #1;
    exp_push = rn && wv && (q.size() < DEPTH);
    exp_pop  = rn && (age >= 2) && rr;
    chk("ram_write", 32'(ram_write), 32'(exp_push));
    if (exp_push) begin
      chk("ram_addr_wr", 32'(ram_addr_wr), 32'(wr_total % DEPTH));
      chk("ram_wdata", 32'(ram_wdata), 32'(wd));
    end
    chk("ram_addr_r", 32'(ram_addr_r), 32'(rd_total % DEPTH));
    if (exp_pop) popped.push_back(rd_data);
    @(posedge clk);
    if (!rn) begin
      q.delete();
      age = 0; wr_total = 0; rd_total = 0;
    end else begin
      had = (q.size() != 0);
      if (exp_pop) begin
        void'(q.pop_front());
        rd_total++;
        age = 0;
      end else if (had && age < 2) begin
        age++;
      end
      if (exp_push) begin
        q.push_back(wd);
        wr_total++;
      end
    end
    @(negedge clk);
    chk("count", 32'(count), 32'(q.size()));
    chk("count_le_depth", 32'(count <= DEPTH), 32'd1);
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
    chk("rd_valid", 32'(rd_valid), 32'(age >= 2));
    if (age >= 2) chk("rd_data", 32'(rd_data), 32'(q[0]));
    if (!rn) chk("rd_data_reset", 32'(rd_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    @(negedge clk);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // single push, simultaneous push/pop, drain
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 6'd1};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 6'd1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 6'd1};
    tbl[3] = '{1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 6'd1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 6'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 6'd1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 6'd0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 6'd0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].wv, tbl[i].wd, tbl[i].rr, 1'b1);
      chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].ec));
    end

    // fill to 32, overflow push is dropped
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_wr_ready", 32'(wr_ready), 32'd0);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    chk("overflow_count", 32'(count), 32'd32);

    // drain all, order 0x00..0x1F
    popped.delete();
    for (int k = 0; k < 200 && popped.size() < DEPTH; k++) step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("drain_n", 32'(popped.size()), 32'd32);
    for (int i = 0; i < popped.size(); i++) chk($sformatf("drain_%0d", i), 32'(popped[i]), 32'(i));
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_valid", 32'(rd_valid), 32'd0);

    // full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
    for (int k = 0; k < 5 && age < 2; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("full_hold_valid", 32'(rd_valid), 32'd1);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("full_pushpop_count", 32'(count), 32'd31);
    step(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("full_repush_count", 32'(count), 32'd32);
    for (int k = 0; k < 200 && q.size() != 0; k++) step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("drain2_empty", 32'(empty), 32'd1);

    // reset while in HOLD with 5 entries
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
    for (int k = 0; k < 5 && age < 2; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("hold5_count", 32'(count), 32'd5);
    chk("hold5_valid", 32'(rd_valid), 32'd1);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    step(1'b1, 8'h3C, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("post_rst_valid", 32'(rd_valid), 32'd1);
    chk("post_rst_head", 32'(rd_data), 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // random traffic, pointers wrap several times
    for (int k = 0; k < 500; k++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0, 1'b1);
    for (int k = 0; k < 200 && q.size() != 0; k++) step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("final_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
